// File: rtl/alu_dsp48a1_core_if.sv
// ALU-to-DSP bus bundle: clock enable, packed op bus in, packed result bus out.
// No handshake; ce stalls every stage of the slice at once.
interface alu_dsp48a1_core_if;
    logic        ce;
    logic [91:0] dsp_ins_flat;
    logic [83:0] dsp_outs_flat;

    modport master (output ce, output dsp_ins_flat, input dsp_outs_flat);
    modport slave  (input ce, input dsp_ins_flat, output dsp_outs_flat);
endinterface

// File: rtl/alu_dsp48a1_core.sv
// Behavioural DSP48A1 slice: pre-negate, 18x18 multiply, X/Z mux, post add/sub into P.
// Latency AREG+MREG+1 edges, one op per cycle.
// No backpressure; ce=0 freezes all stages, including P.
module alu_dsp48a1_core #(
    parameter int AREG = 1,
    parameter int MREG = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_dsp48a1_core_if.slave bus
);
    typedef struct packed {
        logic [7:0]          opmode;
        logic signed [17:0]  a;
        logic signed [17:0]  b;
        logic signed [47:0]  c;
    } dsp_in_t;

    typedef struct packed {
        logic [7:0]          opmode;
        logic signed [17:0]  a;
        logic signed [17:0]  b;
        logic signed [47:0]  c;
        logic signed [35:0]  m;
    } stage2_t;

    dsp_in_t            in_w;
    dsp_in_t            s1;
    stage2_t            s2;
    logic signed [17:0] b_pre;
    logic signed [35:0] m_comb;
    logic signed [35:0] m_out;
    logic [47:0]        x_mux;
    logic [47:0]        z_mux;
    logic [47:0]        cin;
    logic [47:0]        p_next;
    logic [47:0]        p;

    assign in_w = dsp_in_t'(bus.dsp_ins_flat);

    generate
        if (AREG != 0) begin : g_areg
            always_ff @(posedge clk or posedge reset) begin
                if (reset)       s1 <= '0;
                else if (bus.ce) s1 <= in_w;
            end
        end else begin : g_no_areg
            assign s1 = in_w;
        end
    endgenerate

    // No D port, so the pre-adder reduces to an optional negate of b.
    always_comb begin
        b_pre = s1.b;
        if (s1.opmode[6] && s1.opmode[4]) b_pre = -s1.b;
    end

    assign m_comb = s1.a * b_pre;

    generate
        if (MREG != 0) begin : g_mreg
            always_ff @(posedge clk or posedge reset) begin
                if (reset)       s2 <= '0;
                else if (bus.ce) s2 <= {s1.opmode, s1.a, s1.b, s1.c, m_comb};
            end
        end else begin : g_no_mreg
            assign s2 = {s1.opmode, s1.a, s1.b, s1.c, m_comb};
        end
    endgenerate

    // Reset blanks m even when it is a purely combinational view of the inputs.
    assign m_out = reset ? '0 : s2.m;

    always_comb begin
        x_mux = '0;
        case (s2.opmode[1:0])
            2'b01:   x_mux = {{12{s2.m[35]}}, s2.m};
            2'b10:   x_mux = p;
            2'b11:   x_mux = {12'h000, s2.a, s2.b};
            default: x_mux = '0;
        endcase
    end

    // Z=01 selects PCIN, which is unconnected here and reads as zero.
    always_comb begin
        z_mux = '0;
        case (s2.opmode[3:2])
            2'b10:   z_mux = p;
            2'b11:   z_mux = s2.c;
            default: z_mux = '0;
        endcase
    end

    assign cin    = {47'd0, s2.opmode[5]};
    assign p_next = s2.opmode[7] ? (z_mux - (x_mux + cin)) : (z_mux + x_mux + cin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       p <= '0;
        else if (bus.ce) p <= p_next;
    end

    assign bus.dsp_outs_flat = {m_out, p};
endmodule

// File: tb/tb_alu_dsp48a1_core.sv
// Directed bench: three slices (AREG/MREG = 0/0, 1/0, 1/1) share one input stream;
// each result is compared against hand-computed tables shifted by that slice's latency.
module tb_alu_dsp48a1_core;
    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [91:0] in_dat;

    int n_err    = 0;
    int n_checks = 0;

    alu_dsp48a1_core_if bus00 ();
    alu_dsp48a1_core_if bus10 ();
    alu_dsp48a1_core_if bus11 ();

    assign bus00.ce = ce;  assign bus00.dsp_ins_flat = in_dat;
    assign bus10.ce = ce;  assign bus10.dsp_ins_flat = in_dat;
    assign bus11.ce = ce;  assign bus11.dsp_ins_flat = in_dat;

    alu_dsp48a1_core #(.AREG(0), .MREG(0)) u00 (.clk(clk), .reset(reset), .bus(bus00));
    alu_dsp48a1_core #(.AREG(1), .MREG(0)) u10 (.clk(clk), .reset(reset), .bus(bus10));
    alu_dsp48a1_core #(.AREG(1), .MREG(1)) u11 (.clk(clk), .reset(reset), .bus(bus11));

    always #5 clk = ~clk;

    logic [47:0] p_obs [3];
    logic [35:0] m_obs [3];
    assign p_obs[0] = bus00.dsp_outs_flat[47:0];  assign m_obs[0] = bus00.dsp_outs_flat[83:48];
    assign p_obs[1] = bus10.dsp_outs_flat[47:0];  assign m_obs[1] = bus10.dsp_outs_flat[83:48];
    assign p_obs[2] = bus11.dsp_outs_flat[47:0];  assign m_obs[2] = bus11.dsp_outs_flat[83:48];

    int lat [3] = '{1, 2, 3};

    // Op table: inputs plus hand-computed m and p for each op.
    logic [7:0]  s_op [16];
    logic [17:0] s_a  [16];
    logic [17:0] s_b  [16];
    logic [47:0] s_c  [16];
    logic [35:0] s_m  [16];
    logic [47:0] s_p  [16];
    int          s_n;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                         input logic [47:0] c);
        in_dat = {op, a, b, c};
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(8'h08, '0, '0, '0);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                       input logic [47:0] c, input logic [35:0] m, input logic [47:0] p);
        s_op[s_n] = op; s_a[s_n] = a; s_b[s_n] = b; s_c[s_n] = c;
        s_m[s_n]  = m;  s_p[s_n] = p;
        s_n++;
    endtask

    // Play the table followed by NOPs; each slice sees op k retire at edge k+lat.
    task automatic run_seq(input string tag, input int extra);
        int          idx;
        int          midx;
        logic [47:0] exp_p;
        logic [35:0] exp_m;
        for (int k = 0; k < s_n + 2 + extra; k++) begin
            if (k < s_n) drive(s_op[k], s_a[k], s_b[k], s_c[k]);
            else         drive(8'h08, '0, '0, '0);
            step();
            for (int d = 0; d < 3; d++) begin
                idx   = k + 1 - lat[d];
                exp_p = (idx < 0) ? 48'd0 : s_p[(idx < s_n) ? idx : s_n - 1];
                chk($sformatf("%s d%0d k%0d p", tag, d, k), p_obs[d], exp_p);
                midx  = (d == 2) ? k - 1 : k;
                exp_m = (midx < 0 || midx >= s_n) ? 36'd0 : s_m[midx];
                chk($sformatf("%s d%0d k%0d m", tag, d, k), {12'd0, m_obs[d]}, {12'd0, exp_m});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        drive(8'h08, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset d%0d p", d), p_obs[d], 48'd0);
            chk($sformatf("reset d%0d m", d), {12'd0, m_obs[d]}, 48'd0);
        end
        reset = 1'b0;

        // Single multiply, then NOPs hold P.
        s_n = 0;
        add(8'h01, 18'h10000, 18'h08000, 48'd0, 36'h0_8000_0000, 48'h0_8000_0000);
        run_seq("mul", 5);

        // Back-to-back accumulate.
        do_reset(); s_n = 0;
        add(8'h01, 18'd3, 18'd4,  48'd0, 36'd12, 48'd12);
        add(8'h09, 18'd5, -18'sd2, 48'd0, -36'sd10, 48'd2);
        add(8'h09, 18'd7, 18'd1,  48'd0, 36'd7,  48'd9);
        run_seq("acc", 2);

        // Post-subtract with carry, load all-ones, then carry wraps to zero.
        do_reset(); s_n = 0;
        add(8'hAF, 18'd0, 18'd1, 48'd100, 36'd0,  48'd98);
        add(8'h0C, 18'd0, 18'd0, -48'sd1, 36'd0,  48'hFFFF_FFFF_FFFF);
        add(8'h28, 18'd9, 18'd9, 48'd555, 36'd81, 48'd0);
        run_seq("sub", 1);

        // Pre-adder negate, including the most negative b.
        do_reset(); s_n = 0;
        add(8'h51, 18'd2, 18'd5,        48'd0, -36'sd10,     -48'sd10);
        add(8'h51, 18'd2, -18'sd131072, 48'd0, -36'sd262144, -48'sd262144);
        add(8'h41, 18'd2, 18'd5,        48'd0, 36'd10,       48'd10);
        add(8'h11, 18'd2, 18'd5,        48'd0, 36'd10,       48'd10);
        run_seq("pre", 1);

        // X = {a,b} concatenation, then P + P.
        do_reset(); s_n = 0;
        add(8'h03, 18'd1, 18'd2, 48'd0, 36'd2, 48'h4_0002);
        add(8'h0A, 18'd0, 18'd0, 48'd0, 36'd0, 48'h8_0004);
        run_seq("xab", 1);

        // ce low for 4 cycles mid-accumulation freezes every stage.
        do_reset();
        drive(8'h01, 18'd3, 18'd4, 48'd0);   step();
        drive(8'h09, 18'd5, -18'sd2, 48'd0); step();
        drive(8'h09, 18'd7, 18'd1, 48'd0);   step();
        chk("ce pre p", p_obs[2], 48'd12);
        ce = 1'b0;
        drive(8'h09, 18'd100, 18'd100, 48'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("ce hold%0d p", i), p_obs[2], 48'd12);
            chk($sformatf("ce hold%0d m", i), {12'd0, m_obs[2]}, 48'h0_000F_FFFF_FFF6);
            chk($sformatf("ce hold%0d p00", i), p_obs[0], 48'd9);
        end
        ce = 1'b1;
        drive(8'h08, '0, '0, '0);
        step(); chk("ce resume p1", p_obs[2], 48'd2);
        step(); chk("ce resume p2", p_obs[2], 48'd9);
        step(); chk("ce resume p3", p_obs[2], 48'd9);

        // Asynchronous reset between edges aborts in-flight ops.
        do_reset();
        drive(8'h01, 18'd3, 18'd4, 48'd0);   step();
        drive(8'h09, 18'd5, -18'sd2, 48'd0); step();
        drive(8'h09, 18'd7, 18'd1, 48'd0);   step();
        chk("arst pre p", p_obs[2], 48'd12);
        drive(8'h08, '0, '0, '0);
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("arst d%0d p", d), p_obs[d], 48'd0);
            chk($sformatf("arst d%0d m", d), {12'd0, m_obs[d]}, 48'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        s_n = 0;
        add(8'h01, 18'd6, 18'd7, 48'd0, 36'd42, 48'd42);
        run_seq("post", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
